// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store MEM stage: funct3 encodings, FSM states,
// the default bubble instruction and the access-size byte mask helper.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0033;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } lsu_state_e;

  // Byte-lane mask of an access before it is shifted to its lane.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case ({1'b0, size})
      F3_SB:   size_mask = 8'h01;
      F3_SH:   size_mask = 8'h03;
      F3_SW:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-bus req/ack interface between the MEM stage (master) and data memory (slave).
interface lsu_mem_stage_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   wdat;
  logic [XLEN-1:0]   rdat;
  logic              ack;
  logic              err;

  modport master (output req, we, addr, sel, wdat, input rdat, ack, err);
  modport slave  (input req, we, addr, sel, wdat, output rdat, ack, err);
endinterface

// File: rtl/lsu_mem_stage_load_align.sv
// Extracts the addressed byte/half/word from a bus word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] lane_i,
  input  logic [2:0]                funct3_i,
  input  logic [XLEN-1:0]           dat_i,
  output logic [XLEN-1:0]           dat_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = dat_i >> {lane_i, 3'b000};
    case (funct3_i)
      F3_LB:   dat_o = XLEN'($signed(shifted[7:0]));
      F3_LBU:  dat_o = XLEN'(shifted[7:0]);
      F3_LH:   dat_o = XLEN'($signed(shifted[15:0]));
      F3_LHU:  dat_o = XLEN'(shifted[15:0]);
      F3_LW:   dat_o = XLEN'($signed(shifted[31:0]));
      F3_LWU:  dat_o = XLEN'(shifted[31:0]);
      default: dat_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage with MEM/WB register: issues data-bus accesses, aligns loads, stalls and drains.
// Define MEM_MISALIGN_EXC_EN to trap misaligned accesses instead of truncating the address.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  mem_pc_i,
  input  logic [31:0]      mem_instruction_i,
  input  logic [XLEN-1:0]  mem_result_i,
  input  logic [4:0]       mem_waddr_i,
  input  logic             mem_we_i,
  input  logic             mem_load_i,
  input  logic             mem_store_i,
  input  logic [2:0]       mem_funct3_i,
  input  logic [XLEN-1:0]  mem_store_dat_i,
  input  logic [2:0]       mem_csr_op_i,
  input  logic             mem_csr_imm_op_i,
  input  logic             mem_exc_addr_if_i,
  lsu_mem_stage_if.master  dmem,
  output logic             stall_req_o,
  output logic [XLEN-1:0]  forward_mem_dat_o,
  output logic [XLEN-1:0]  wb_pc_o,
  output logic [31:0]      wb_instruction_o,
  output logic [XLEN-1:0]  wb_result_o,
  output logic [4:0]       wb_waddr_o,
  output logic             wb_we_o,
  output logic [2:0]       wb_csr_op_o,
  output logic             wb_csr_imm_op_o,
  output logic             wb_exc_addr_if_o,
`ifdef MEM_MISALIGN_EXC_EN
  output logic             wb_exc_load_misalign_o,
`endif
  output logic             wb_exc_load_fault_o
);

  localparam int LW   = $clog2(XLEN/8);
  localparam int SELW = XLEN/8;

  lsu_state_e state_q, state_d;

  logic [XLEN-1:0] hold_dat_q, hold_dat_d;
  logic            hold_err_q, hold_err_d;
  logic            req_we_q, req_we_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [SELW-1:0] req_sel_q, req_sel_d;
  logic [XLEN-1:0] req_wdat_q, req_wdat_d;

  logic [XLEN-1:0] wb_pc_q, wb_pc_d;
  logic [31:0]     wb_instruction_q, wb_instruction_d;
  logic [XLEN-1:0] wb_result_q, wb_result_d;
  logic [4:0]      wb_waddr_q, wb_waddr_d;
  logic            wb_we_q, wb_we_d;
  logic [2:0]      wb_csr_op_q, wb_csr_op_d;
  logic            wb_csr_imm_op_q, wb_csr_imm_op_d;
  logic            wb_exc_addr_if_q, wb_exc_addr_if_d;
  logic            wb_exc_load_fault_q, wb_exc_load_fault_d;
`ifdef MEM_MISALIGN_EXC_EN
  logic            wb_exc_load_misalign_q, wb_exc_load_misalign_d;
`endif

  logic [LW-1:0]   raw_lane, align_mask, lane;
  logic            mem_op, misalign, access, done;
  logic            req, stall_req, req_out;
  logic            wb_cap, wb_bub, use_hold, cap_err, fault;
  logic [XLEN-1:0] align_dat, store_dat, cur_addr;
  logic [SELW-1:0] cur_sel;

  assign raw_lane = mem_result_i[LW-1:0];
  assign mem_op   = mem_load_i | mem_store_i;
  assign done     = dmem.ack | dmem.err;

  always_comb begin
    align_mask = '0;
    case (mem_funct3_i[1:0])
      2'd1:    align_mask = LW'(1);
      2'd2:    align_mask = LW'(3);
      2'd3:    align_mask = LW'(7);
      default: align_mask = '0;
    endcase
  end

  assign lane = raw_lane & ~align_mask;

`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = mem_op & (|(raw_lane & align_mask));
`else
  assign misalign = 1'b0;
`endif

  assign access = mem_op & ~flush_i & ~misalign;

  load_align #(.XLEN(XLEN)) u_load_align (
    .lane_i   (lane),
    .funct3_i (mem_funct3_i),
    .dat_i    (dmem.rdat),
    .dat_o    (align_dat)
  );

  always_comb begin
    case (mem_funct3_i[1:0])
      2'd0:    store_dat = {(XLEN/8){mem_store_dat_i[7:0]}};
      2'd1:    store_dat = {(XLEN/16){mem_store_dat_i[15:0]}};
      2'd2:    store_dat = {(XLEN/32){mem_store_dat_i[31:0]}};
      default: store_dat = mem_store_dat_i;
    endcase
  end

  assign cur_addr = {mem_result_i[XLEN-1:LW], {LW{1'b0}}};
  assign cur_sel  = SELW'(size_mask(mem_funct3_i[1:0])) << lane;

  // The request is captured at issue so a drain keeps presenting the orphaned access.
  always_comb begin
    req_we_d   = req_we_q;
    req_addr_d = req_addr_q;
    req_sel_d  = req_sel_q;
    req_wdat_d = req_wdat_q;
    if (state_q == ST_IDLE && access) begin
      req_we_d   = mem_store_i;
      req_addr_d = cur_addr;
      req_sel_d  = cur_sel;
      req_wdat_d = mem_store_i ? store_dat : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    stall_req  = 1'b0;
    wb_cap     = 1'b0;
    wb_bub     = 1'b0;
    use_hold   = 1'b0;
    cap_err    = 1'b0;
    hold_dat_d = hold_dat_q;
    hold_err_d = hold_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          req       = 1'b1;
          stall_req = 1'b1;
          wb_bub    = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          wb_cap = 1'b1;
        end
      end
      ST_WAIT: begin
        req       = 1'b1;
        stall_req = ~done;
        if (flush_i) begin
          state_d = done ? ST_IDLE : ST_DRAIN;
        end else if (done) begin
          if (stall_i) begin
            hold_dat_d = align_dat;
            hold_err_d = dmem.err;
            state_d    = ST_HOLD;
          end else begin
            wb_cap  = 1'b1;
            cap_err = dmem.err;
            state_d = ST_IDLE;
          end
        end else begin
          wb_bub = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (!stall_i) begin
          wb_cap   = 1'b1;
          use_hold = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        req = 1'b1;
        if (done) state_d = ST_IDLE;
        if (mem_op) begin
          stall_req = 1'b1;
          wb_bub    = 1'b1;
        end else begin
          wb_cap = 1'b1;
        end
      end
    endcase
  end

  // Reset gates the request combinationally so a pending access is dropped at once.
  assign req_out     = req & ~rst_i;
  assign stall_req_o = stall_req & ~rst_i;

  assign dmem.req  = req_out;
  assign dmem.we   = req_out & ((state_q == ST_IDLE) ? mem_store_i : req_we_q);
  assign dmem.addr = !req_out ? '0 : (state_q == ST_IDLE) ? cur_addr : req_addr_q;
  assign dmem.sel  = !req_out ? '0 : (state_q == ST_IDLE) ? cur_sel : req_sel_q;
  assign dmem.wdat = !req_out ? '0 :
                     (state_q == ST_IDLE) ? (mem_store_i ? store_dat : '0) : req_wdat_q;

  assign forward_mem_dat_o = !mem_load_i ? mem_result_i :
                             (state_q == ST_HOLD) ? hold_dat_q : align_dat;

  always_comb begin
    fault               = use_hold ? hold_err_q : cap_err;
    wb_pc_d             = wb_pc_q;
    wb_instruction_d    = wb_instruction_q;
    wb_result_d         = wb_result_q;
    wb_waddr_d          = wb_waddr_q;
    wb_we_d             = wb_we_q;
    wb_csr_op_d         = wb_csr_op_q;
    wb_csr_imm_op_d     = wb_csr_imm_op_q;
    wb_exc_addr_if_d    = wb_exc_addr_if_q;
    wb_exc_load_fault_d = wb_exc_load_fault_q;
`ifdef MEM_MISALIGN_EXC_EN
    wb_exc_load_misalign_d = wb_exc_load_misalign_q;
`endif
    if (flush_i || (!stall_i && !wb_cap && wb_bub)) begin
      wb_pc_d             = '0;
      wb_instruction_d    = NOP_INSTR;
      wb_result_d         = '0;
      wb_waddr_d          = '0;
      wb_we_d             = 1'b0;
      wb_csr_op_d         = '0;
      wb_csr_imm_op_d     = 1'b0;
      wb_exc_addr_if_d    = 1'b0;
      wb_exc_load_fault_d = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      wb_exc_load_misalign_d = 1'b0;
`endif
    end else if (!stall_i && wb_cap) begin
      wb_pc_d             = mem_pc_i;
      wb_instruction_d    = mem_instruction_i;
      wb_result_d         = !mem_load_i ? mem_result_i : use_hold ? hold_dat_q : align_dat;
      wb_waddr_d          = mem_waddr_i;
      wb_we_d             = mem_we_i & ~fault & ~misalign;
      wb_csr_op_d         = mem_csr_op_i;
      wb_csr_imm_op_d     = mem_csr_imm_op_i;
      wb_exc_addr_if_d    = mem_exc_addr_if_i;
      wb_exc_load_fault_d = fault;
`ifdef MEM_MISALIGN_EXC_EN
      wb_exc_load_misalign_d = misalign;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q             <= ST_IDLE;
      hold_dat_q          <= '0;
      hold_err_q          <= 1'b0;
      req_we_q            <= 1'b0;
      req_addr_q          <= '0;
      req_sel_q           <= '0;
      req_wdat_q          <= '0;
      wb_pc_q             <= '0;
      wb_instruction_q    <= NOP_INSTR;
      wb_result_q         <= '0;
      wb_waddr_q          <= '0;
      wb_we_q             <= 1'b0;
      wb_csr_op_q         <= '0;
      wb_csr_imm_op_q     <= 1'b0;
      wb_exc_addr_if_q    <= 1'b0;
      wb_exc_load_fault_q <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      wb_exc_load_misalign_q <= 1'b0;
`endif
    end else begin
      state_q             <= state_d;
      hold_dat_q          <= hold_dat_d;
      hold_err_q          <= hold_err_d;
      req_we_q            <= req_we_d;
      req_addr_q          <= req_addr_d;
      req_sel_q           <= req_sel_d;
      req_wdat_q          <= req_wdat_d;
      wb_pc_q             <= wb_pc_d;
      wb_instruction_q    <= wb_instruction_d;
      wb_result_q         <= wb_result_d;
      wb_waddr_q          <= wb_waddr_d;
      wb_we_q             <= wb_we_d;
      wb_csr_op_q         <= wb_csr_op_d;
      wb_csr_imm_op_q     <= wb_csr_imm_op_d;
      wb_exc_addr_if_q    <= wb_exc_addr_if_d;
      wb_exc_load_fault_q <= wb_exc_load_fault_d;
`ifdef MEM_MISALIGN_EXC_EN
      wb_exc_load_misalign_q <= wb_exc_load_misalign_d;
`endif
    end
  end

  assign wb_pc_o             = wb_pc_q;
  assign wb_instruction_o    = wb_instruction_q;
  assign wb_result_o         = wb_result_q;
  assign wb_waddr_o          = wb_waddr_q;
  assign wb_we_o             = wb_we_q;
  assign wb_csr_op_o         = wb_csr_op_q;
  assign wb_csr_imm_op_o     = wb_csr_imm_op_q;
  assign wb_exc_addr_if_o    = wb_exc_addr_if_q;
  assign wb_exc_load_fault_o = wb_exc_load_fault_q;
`ifdef MEM_MISALIGN_EXC_EN
  assign wb_exc_load_misalign_o = wb_exc_load_misalign_q;
`endif

endmodule
